// File: rtl/rr_sel_arbiter_pkg.sv
// Shared constants and types for the round-robin select arbiter.
//   N    : number of requesters (fixed at 8)
//   SELW : width of the binary select code
//   W    : data width per requester
package rr_sel_pkg;

  localparam int N    = 8;
  localparam int SELW = 3;
  localparam int W    = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  typedef logic [W-1:0] data_t;

endpackage

// File: rtl/rr_sel_arbiter_if.sv
// Requester-side bus of the select arbiter.
//   req  : per-requester level request
//   a    : per-requester data, a[i] belongs to requester i
//   gnt  : one-hot grant
//   sel  : binary index of current/last owner
//   busy : high while a grant is active
//   y    : a[sel] while busy, else 0
// master = requester side, slave = arbiter side.
interface rr_sel_arbiter_if;
  import rr_sel_pkg::*;

  logic [N-1:0]    req;
  data_t [N-1:0]   a;
  logic [N-1:0]    gnt;
  logic [SELW-1:0] sel;
  logic            busy;
  data_t           y;

  modport master (output req, a, input gnt, sel, busy, y);
  modport slave  (input req, a, output gnt, sel, busy, y);

endinterface

// File: rtl/rr_sel_arbiter_pick.sv
// rr_pick: combinational rotate-priority finder.
//   req   : request vector
//   ptr   : index that has highest priority
//   found : some request is set
//   idx   : first set request scanning ptr, ptr+1, ... mod N
module rr_pick
  import rr_sel_pkg::*;
(
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic            found,
  output logic [SELW-1:0] idx
);

  logic [N-1:0]    rot;
  logic [SELW-1:0] off;

  always_comb begin
    // rot[i] is the request i places after ptr; 3-bit sum wraps mod 8
    for (int i = 0; i < N; i++) begin
      rot[i] = req[SELW'(i) + ptr];
    end
    found = |rot;
    off   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = SELW'(i);
    end
    idx = off + ptr;
  end

endmodule

// File: rtl/rr_sel_arbiter.sv
// rr_sel_arbiter: round-robin arbiter sharing one 8-way select datapath.
//   clk      : system clock, rising edge
//   rst      : asynchronous active-high reset
//   bus      : requester bus (req, a in; gnt, sel, busy, y out)
//   MAX_HOLD : max consecutive grant cycles while others wait, 0 = no limit
//
// state   | meaning
// IDLE    | no grant, waiting for any request
// GRANT   | one requester owns the datapath
// RELEASE | single turnaround cycle with gnt=0, ptr already advanced
module rr_sel_arbiter
  import rr_sel_pkg::*;
#(
  parameter int MAX_HOLD = 15
) (
  input logic             clk,
  input logic             rst,
  rr_sel_arbiter_if.slave bus
);

  localparam int  HOLD_LAST  = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam int  CNTW       = (HOLD_LAST > 1) ? $clog2(HOLD_LAST + 1) : 1;
  localparam bit  TIMEOUT_EN = (MAX_HOLD != 0);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(HOLD_LAST);

  arb_state_t      state_q, state_n;
  logic [N-1:0]    gnt_q, gnt_n;
  logic [SELW-1:0] sel_q, sel_n;
  logic            busy_q, busy_n;
  logic [SELW-1:0] ptr_q, ptr_n;
  logic [CNTW-1:0] cnt_q, cnt_n;

  logic            found;
  logic [SELW-1:0] pick_idx;
  logic            others_pending;
  logic            timeout;

  rr_pick u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .found (found),
    .idx   (pick_idx)
  );

  assign others_pending = |(bus.req & ~gnt_q);
  assign timeout        = TIMEOUT_EN && (cnt_q == CNT_LAST) && others_pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      gnt_q   <= gnt_n;
      sel_q   <= sel_n;
      busy_q  <= busy_n;
      ptr_q   <= ptr_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state_q;
    gnt_n   = gnt_q;
    sel_n   = sel_q;
    busy_n  = busy_q;
    ptr_n   = ptr_q;
    cnt_n   = cnt_q;
    unique case (state_q)
      // ptr is advanced on entry to RELEASE, so the turnaround cycle can
      // already pick the next owner; this keeps the gap to one cycle.
      IDLE, RELEASE: begin
        if (found) begin
          state_n         = GRANT;
          gnt_n           = '0;
          gnt_n[pick_idx] = 1'b1;
          sel_n           = pick_idx;
          busy_n          = 1'b1;
          cnt_n           = '0;
        end else begin
          state_n = IDLE;
        end
      end
      GRANT: begin
        if (!bus.req[sel_q] || timeout) begin
          state_n = RELEASE;
          gnt_n   = '0;
          busy_n  = 1'b0;
          ptr_n   = sel_q + 1'b1;
        end else if (TIMEOUT_EN && (cnt_q != CNT_LAST)) begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

  assign bus.gnt  = gnt_q;
  assign bus.sel  = sel_q;
  assign bus.busy = busy_q;
  assign bus.y    = busy_q ? bus.a[sel_q] : '0;

endmodule
